// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with modulo MAX_COUNT+1, parallel load, terminal count and sticky overflow.
// Build option: define UPDN_COUNTER_SATURATE_EN to hold at the end values instead of wrapping.
module param_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf_flag
);

  localparam logic [WIDTH-1:0] MAXQ = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RSTQ = WIDTH'(RESET_VAL);

  logic             at_top;
  logic             at_bot;
  logic             wrap_evt;
  logic [WIDTH-1:0] load_q;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    at_top = (q == MAXQ);
    at_bot = (q == '0);
    tc     = en & ((up_dn & at_top) | (~up_dn & at_bot));
    // A load preempts the step, so tc alone does not imply a wrap.
    wrap_evt = tc & ~load;
    load_q   = (load_val > MAXQ) ? MAXQ : load_val;
  end

  always_comb begin
    q_next = q;
    if (load) begin
      q_next = load_q;
    end else if (en) begin
      if (up_dn) begin
        if (at_top) begin
`ifdef UPDN_COUNTER_SATURATE_EN
          q_next = q;
`else
          q_next = '0;
`endif
        end else begin
          q_next = q + WIDTH'(1);
        end
      end else begin
        if (at_bot) begin
`ifdef UPDN_COUNTER_SATURATE_EN
          q_next = q;
`else
          q_next = MAXQ;
`endif
        end else begin
          q_next = q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= RSTQ;
      ovf_flag <= 1'b0;
    end else begin
      q <= q_next;
      if (wrap_evt)
        ovf_flag <= 1'b1;
      else if (clr_ovf)
        ovf_flag <= 1'b0;
    end
  end

endmodule
